shift_cmd_queue: RTL

Command queue and issue stage directly upstream of the 8-bit barrel shifter. Buffers (data, shift-amount) commands in a small FIFO and drives them one at a time onto the shifter's `in`/`ctrl` from registers. Captures the shifter's `out` one cycle later and presents it with a valid/ready handshake. This decouples a bursty producer from the combinational shifter and gives the shifter path a full cycle of registered inputs.

---
 rtl/shift_cmd_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/shift_cmd_queue.sv
// Command FIFO and issue stage in front of a combinational barrel shifter.
// Holds shifter inputs in registers for a full cycle and captures the result.
module shift_cmd_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DW-1:0]            cmd_data_i,
  input  logic [CW-1:0]            cmd_shamt_i,
  output logic [DW-1:0]            bs_in_o,
  output logic [CW-1:0]            bs_ctrl_o,
  input  logic [DW-1:0]            bs_out_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DW-1:0]            res_data_o,
  output logic [CW-1:0]            res_shamt_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  logic [DW-1:0] data_q  [DEPTH];
  logic [CW-1:0] shamt_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  state_e        state_q;
  logic [DW-1:0] bs_in_q, res_data_q;
  logic [CW-1:0] bs_ctrl_q, res_shamt_q;
  logic          res_valid_q;

  logic not_empty, full, push, pop;

  assign not_empty   = (level_q != '0);
  assign full        = (level_q == LW'(DEPTH));
  // Registered level only: a same-cycle pop never opens a slot early.
  assign cmd_ready_o = !rst_i && !full;
  assign push        = cmd_valid_i && cmd_ready_o;

  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = not_empty;
      StHold:  pop = res_ready_i && not_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q]  <= cmd_data_i;
        shamt_q[wr_ptr_q] <= cmd_shamt_i;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bs_in_q     <= '0;
      bs_ctrl_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_shamt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            bs_in_q   <= data_q[rd_ptr_q];
            bs_ctrl_q <= shamt_q[rd_ptr_q];
            state_q   <= StShift;
          end
        end
        StShift: begin
          // Shifter inputs have now been stable for a whole cycle.
          res_data_q  <= bs_out_i;
          res_shamt_q <= bs_ctrl_q;
          res_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              bs_in_q   <= data_q[rd_ptr_q];
              bs_ctrl_q <= shamt_q[rd_ptr_q];
              state_q   <= StShift;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bs_in_o     = bs_in_q;
  assign bs_ctrl_o   = bs_ctrl_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_shamt_o = res_shamt_q;
  assign level_o     = level_q;

endmodule
